writeback_commit_ctrl: RTL

Parametrised writeback commit controller at the end of the pipeline. It qualifies each register, segment, MMX, flag and memory write with its condition mode (CMPXCHG on ZF, CMOV-style on CF). It registers the resulting one-cycle write-enable pulses. When a memory write is committed, it stalls the WB stage and holds every architectural write until the memory store is acknowledged, so register, flag and memory state update in the same cycle.

---
 rtl/writeback_commit_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/writeback_commit_ctrl.sv
// Writeback commit controller: qualifies architectural writes by condition and stalls on stores.
// Optional COMMIT_STATS_EN adds stat_commits / stat_suppressed counters.
module writeback_commit_ctrl #(
    parameter int unsigned NUM_REG  = 3,
    parameter int unsigned STRB_W   = 4,
    parameter int unsigned NUM_FLAG = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic                        flush,
    input  logic                        ZF_new,
    input  logic                        CF_flag,
    input  logic                        CF_expected,
    input  logic [NUM_REG-1:0]          ld_reg,
    input  logic [NUM_REG*STRB_W-1:0]   ld_reg_strb,
    input  logic [2*NUM_REG-1:0]        reg_cond,
    input  logic                        ld_mem,
    input  logic [1:0]                  mem_cond,
    input  logic                        ld_seg,
    input  logic                        ld_mm,
    input  logic [NUM_FLAG-1:0]         ld_flag,
    input  logic                        mem_ack,
    output logic                        mem_req,
    output logic [NUM_REG-1:0]          v_ld_reg,
    output logic [NUM_REG*STRB_W-1:0]   v_ld_reg_strb,
    output logic                        v_ld_seg,
    output logic                        v_ld_mm,
    output logic [NUM_FLAG-1:0]         v_ld_flag,
    output logic                        v_ld_mem
`ifdef COMMIT_STATS_EN
    ,
    output logic [31:0]                 stat_commits,
    output logic [31:0]                 stat_suppressed
`endif
);

    typedef enum logic [0:0] {StIdle, StMemWait} state_e;

    state_e state_q, state_d;

    logic [NUM_REG-1:0]        qual_reg;
    logic [NUM_REG*STRB_W-1:0] qual_strb;
    logic                      qual_mem;
    logic                      accept;
    logic                      mem_go;
    logic                      ack_commit;

    logic [NUM_REG-1:0]        hold_reg_q;
    logic [NUM_REG*STRB_W-1:0] hold_strb_q;
    logic                      hold_seg_q, hold_mm_q;
    logic [NUM_FLAG-1:0]       hold_flag_q;

    logic [NUM_REG-1:0]        v_reg_q, v_reg_d;
    logic [NUM_REG*STRB_W-1:0] v_strb_q, v_strb_d;
    logic                      v_seg_q, v_seg_d, v_mm_q, v_mm_d, v_mem_q, v_mem_d;
    logic [NUM_FLAG-1:0]       v_flag_q, v_flag_d;

    function automatic logic cond_ok(input logic [1:0] c, input logic zf, input logic cf,
                                     input logic cf_exp);
        unique case (c)
            2'b00:   return 1'b1;
            2'b01:   return zf;
            2'b10:   return ~zf;
            default: return cf == cf_exp;
        endcase
    endfunction

    always_comb begin
        qual_reg  = '0;
        qual_strb = '0;
        for (int unsigned i = 0; i < NUM_REG; i++) begin
            qual_reg[i] = ld_reg[i] & cond_ok(reg_cond[2*i +: 2], ZF_new, CF_flag, CF_expected);
            qual_strb[i*STRB_W +: STRB_W] = ld_reg_strb[i*STRB_W +: STRB_W] & {STRB_W{qual_reg[i]}};
        end
        qual_mem = ld_mem & cond_ok(mem_cond, ZF_new, CF_flag, CF_expected);
    end

    assign accept     = wb_valid & wb_ready & ~flush;
    assign mem_go     = accept & qual_mem;
    assign ack_commit = (state_q == StMemWait) & mem_ack;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (mem_go) state_d = StMemWait;
            StMemWait: if (mem_ack) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        wb_ready = (state_q == StIdle);
        mem_req  = (state_q == StMemWait);
    end

    // Commit pulses come either straight from an accepted uop or from the hold registers on ack.
    always_comb begin
        v_reg_d  = '0;
        v_strb_d = '0;
        v_seg_d  = 1'b0;
        v_mm_d   = 1'b0;
        v_flag_d = '0;
        v_mem_d  = 1'b0;
        if (accept && !mem_go) begin
            v_reg_d  = qual_reg;
            v_strb_d = qual_strb;
            v_seg_d  = ld_seg;
            v_mm_d   = ld_mm;
            v_flag_d = ld_flag;
        end else if (ack_commit) begin
            v_reg_d  = hold_reg_q;
            v_strb_d = hold_strb_q;
            v_seg_d  = hold_seg_q;
            v_mm_d   = hold_mm_q;
            v_flag_d = hold_flag_q;
            v_mem_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg_q  <= '0;
            hold_strb_q <= '0;
            hold_seg_q  <= 1'b0;
            hold_mm_q   <= 1'b0;
            hold_flag_q <= '0;
            v_reg_q     <= '0;
            v_strb_q    <= '0;
            v_seg_q     <= 1'b0;
            v_mm_q      <= 1'b0;
            v_flag_q    <= '0;
            v_mem_q     <= 1'b0;
        end else begin
            if (mem_go) begin
                hold_reg_q  <= qual_reg;
                hold_strb_q <= qual_strb;
                hold_seg_q  <= ld_seg;
                hold_mm_q   <= ld_mm;
                hold_flag_q <= ld_flag;
            end
            v_reg_q  <= v_reg_d;
            v_strb_q <= v_strb_d;
            v_seg_q  <= v_seg_d;
            v_mm_q   <= v_mm_d;
            v_flag_q <= v_flag_d;
            v_mem_q  <= v_mem_d;
        end
    end

    assign v_ld_reg      = v_reg_q;
    assign v_ld_reg_strb = v_strb_q;
    assign v_ld_seg      = v_seg_q;
    assign v_ld_mm       = v_mm_q;
    assign v_ld_flag     = v_flag_q;
    assign v_ld_mem      = v_mem_q;

`ifdef COMMIT_STATS_EN
    logic [31:0] commits_q, suppressed_q;
    logic        dropped;

    assign dropped = (|(ld_reg & ~qual_reg)) | (ld_mem & ~qual_mem);

    // A uop counts as committed when its pulse is issued, even if every write was suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            commits_q    <= '0;
            suppressed_q <= '0;
        end else begin
            if ((accept && !mem_go) || ack_commit) commits_q <= commits_q + 32'd1;
            if (accept && dropped) suppressed_q <= suppressed_q + 32'd1;
        end
    end

    assign stat_commits    = commits_q;
    assign stat_suppressed = suppressed_q;
`endif

endmodule
